// File: rtl/anton_neopixel_stream_seq_if.sv
// Register-side controls and stream-side status of the NeoPixel stream sequencer.
// master = register file / output stage, slave = sequencer.
interface anton_neopixel_stream_seq_if #(
  parameter int unsigned BUFFER_BITS = 8,
  parameter int unsigned CH_BITS     = 1,
  parameter int unsigned PAT_BITS    = 3
);
  logic                   reg_ctrl_init;
  logic                   reg_ctrl_run;
  logic                   reg_ctrl_limit;
  logic                   reg_ctrl_32bit;
  logic                   reg_ctrl_rgbw;
  logic                   reg_ctrl_loop;
  logic [12:0]            reg_max;
  logic [CH_BITS-1:0]     reg_chan_max;

  logic [1:0]             state;
  logic [PAT_BITS-1:0]    bit_pattern_index;
  logic [4:0]             pixel_bit_index;
  logic [BUFFER_BITS-1:0] pixel_index;
  logic [BUFFER_BITS-1:0] pixel_index_max;
  logic [CH_BITS-1:0]     channel_index;
  logic                   stream_output;
  logic                   stream_reset;
  logic                   stream_bit_of;
  logic                   stream_pixel_of;
  logic                   frame_done;

  modport master (
    output reg_ctrl_init, reg_ctrl_run, reg_ctrl_limit, reg_ctrl_32bit,
           reg_ctrl_rgbw, reg_ctrl_loop, reg_max, reg_chan_max,
    input  state, bit_pattern_index, pixel_bit_index, pixel_index, pixel_index_max,
           channel_index, stream_output, stream_reset, stream_bit_of,
           stream_pixel_of, frame_done
  );

  modport slave (
    input  reg_ctrl_init, reg_ctrl_run, reg_ctrl_limit, reg_ctrl_32bit,
           reg_ctrl_rgbw, reg_ctrl_loop, reg_max, reg_chan_max,
    output state, bit_pattern_index, pixel_bit_index, pixel_index, pixel_index_max,
           channel_index, stream_output, stream_reset, stream_bit_of,
           stream_pixel_of, frame_done
  );
endinterface

// File: rtl/anton_neopixel_stream_seq.sv
// NeoPixel stream sequencer: IDLE/TRANSMIT/RESET FSM with sub-bit, bit, pixel and
// channel counters; frame configuration is snapshotted on every entry to TRANSMIT.
module anton_neopixel_stream_seq #(
  parameter int unsigned BUFFER_END    = 255,
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned PATTERN_STEPS = 8,
  parameter int unsigned RESET_CYCLES  = 350
) (
  input  logic                         clk7mhz,
  input  logic                         rst_n,
  anton_neopixel_stream_seq_if.slave   bus
);
  localparam int unsigned BUFFER_BITS = (BUFFER_END < 1) ? 1 : $clog2(BUFFER_END + 1);
  localparam int unsigned CH_BITS     = (CHANNELS < 3) ? 1 : $clog2(CHANNELS);
  localparam int unsigned PAT_BITS    = $clog2(PATTERN_STEPS);
  localparam int unsigned RST_BITS    = $clog2(RESET_CYCLES);

  localparam logic [BUFFER_BITS:0]   BEND_W   = (BUFFER_BITS+1)'(BUFFER_END);
  localparam logic [CH_BITS:0]       CH_LAST  = (CH_BITS+1)'(CHANNELS - 1);
  localparam logic [PAT_BITS-1:0]    PAT_LAST = PAT_BITS'(PATTERN_STEPS - 1);
  localparam logic [RST_BITS-1:0]    RST_LAST = RST_BITS'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRANSMIT = 2'd1,
    ST_RESET    = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PAT_BITS-1:0]    pat_q, pat_d;
  logic [4:0]             bit_q, bit_d;
  logic [BUFFER_BITS-1:0] pix_q, pix_d;
  logic [CH_BITS-1:0]     chan_q, chan_d;
  logic [RST_BITS-1:0]    rcnt_q, rcnt_d;
  logic                   c32_q, c32_d;
  logic                   rgbw_q, rgbw_d;
  logic                   lim_q, lim_d;
  logic [BUFFER_BITS-1:0] max_q, max_d;
  logic [CH_BITS-1:0]     cmax_q, cmax_d;

  logic                   pattern_of, bit_last, bit_of, pixel_of, snapshot;
  logic [BUFFER_BITS-1:0] pix_equiv, pmax;
  logic                   unused_reg_max;

  assign unused_reg_max = ^bus.reg_max;

  assign pattern_of = (pat_q == PAT_LAST);
  assign bit_last   = (bit_q == (rgbw_q ? 5'd31 : 5'd23));
  assign bit_of     = (state_q == ST_TRANSMIT) && pattern_of && bit_last;
  // Word-aligned mode compares the last pixel of the 4-pixel group so the step of 4 can't skip the limit.
  assign pix_equiv  = c32_q ? (pix_q | BUFFER_BITS'(3)) : pix_q;
  assign pmax       = (lim_q && ({1'b0, max_q} <= BEND_W)) ? max_q : BEND_W[BUFFER_BITS-1:0];
  assign pixel_of   = bit_of && (pix_equiv >= pmax);

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    bit_d    = bit_q;
    pix_d    = pix_q;
    chan_d   = chan_q;
    rcnt_d   = rcnt_q;
    c32_d    = c32_q;
    rgbw_d   = rgbw_q;
    lim_d    = lim_q;
    max_d    = max_q;
    cmax_d   = cmax_q;
    snapshot = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.reg_ctrl_run) begin
          state_d  = ST_TRANSMIT;
          snapshot = 1'b1;
        end
      end
      ST_TRANSMIT: begin
        if (!bus.reg_ctrl_run) begin
          state_d = ST_RESET;
          pat_d   = '0;
          bit_d   = '0;
          pix_d   = '0;
          chan_d  = '0;
          rcnt_d  = '0;
        end else begin
          pat_d = pattern_of ? '0 : pat_q + PAT_BITS'(1);
          if (pattern_of) bit_d = bit_last ? '0 : bit_q + 5'd1;
          if (pixel_of) begin
            pix_d = '0;
            if (chan_q < cmax_q) begin
              chan_d = chan_q + CH_BITS'(1);
            end else begin
              chan_d  = '0;
              state_d = ST_RESET;
              rcnt_d  = '0;
            end
          end else if (bit_of) begin
            pix_d = pix_q + (c32_q ? BUFFER_BITS'(4) : BUFFER_BITS'(1));
          end
        end
      end
      ST_RESET: begin
        if (rcnt_q == RST_LAST) begin
          rcnt_d = '0;
          if (bus.reg_ctrl_loop && bus.reg_ctrl_run) begin
            state_d  = ST_TRANSMIT;
            snapshot = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          rcnt_d = rcnt_q + RST_BITS'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (snapshot) begin
      c32_d  = bus.reg_ctrl_32bit;
      rgbw_d = bus.reg_ctrl_rgbw;
      lim_d  = bus.reg_ctrl_limit;
      max_d  = bus.reg_max[BUFFER_BITS-1:0];
      cmax_d = ({1'b0, bus.reg_chan_max} > CH_LAST) ? CH_LAST[CH_BITS-1:0] : bus.reg_chan_max;
    end

    if (bus.reg_ctrl_init) begin
      state_d = ST_IDLE;
      pat_d   = '0;
      bit_d   = '0;
      pix_d   = '0;
      chan_d  = '0;
      rcnt_d  = '0;
      c32_d   = 1'b0;
      rgbw_d  = 1'b0;
      lim_d   = 1'b0;
      max_d   = '0;
      cmax_d  = '0;
    end
  end

  always_ff @(posedge clk7mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      chan_q  <= '0;
      rcnt_q  <= '0;
      c32_q   <= 1'b0;
      rgbw_q  <= 1'b0;
      lim_q   <= 1'b0;
      max_q   <= '0;
      cmax_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      chan_q  <= chan_d;
      rcnt_q  <= rcnt_d;
      c32_q   <= c32_d;
      rgbw_q  <= rgbw_d;
      lim_q   <= lim_d;
      max_q   <= max_d;
      cmax_q  <= cmax_d;
    end
  end

  assign bus.state             = state_q;
  assign bus.bit_pattern_index = pat_q;
  assign bus.pixel_bit_index   = bit_q;
  assign bus.pixel_index       = pix_q;
  assign bus.pixel_index_max   = pmax;
  assign bus.channel_index     = chan_q;
  assign bus.stream_output     = (state_q == ST_TRANSMIT);
  assign bus.stream_reset      = (state_q == ST_RESET);
  assign bus.stream_bit_of     = bit_of;
  assign bus.stream_pixel_of   = pixel_of;
  assign bus.frame_done        = (state_q == ST_RESET) && (rcnt_q == RST_LAST);
endmodule

// File: tb/tb_anton_neopixel_stream_seq.sv
// Bench for the NeoPixel stream sequencer: expected per-cycle traces are built from
// frame geometry (channels x pixels x bits x steps, then the latch gap).
module tb_anton_neopixel_stream_seq;
  localparam int BE = 11;
  localparam int CH = 3;
  localparam int PS = 8;
  localparam int RC = 350;

  typedef struct {
    bit        b32, rgbw, limit;
    bit [12:0] rmax;
    bit [1:0]  chan;
  } cfg_t;

  typedef struct {
    bit [1:0] st;
    bit [2:0] pat;
    bit [4:0] pbit;
    bit [3:0] pix, pmax;
    bit [1:0] chan;
    bit       bof, pof, fd;
  } exp_t;

  typedef struct {
    cfg_t cfg;
    int   exp_tx;
    int   exp_pmax;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  anton_neopixel_stream_seq_if #(.BUFFER_BITS(4), .CH_BITS(2), .PAT_BITS(3)) bus ();

  anton_neopixel_stream_seq #(
    .BUFFER_END(BE), .CHANNELS(CH), .PATTERN_STEPS(PS), .RESET_CYCLES(RC)
  ) dut (
    .clk7mhz(clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  exp_t exp_q[$];
  int   cur_pmax = BE;
  int   n_vec = 0;
  int   n_fail = 0;
  int   tx_seen = 0;

  function automatic int pmax_of(cfg_t c);
    int m;
    m = int'(c.rmax[3:0]);
    return c.limit ? ((m > BE) ? BE : m) : BE;
  endfunction

  function automatic exp_t mk(int st, int pat, int pb, int pix, int ch, bit bof, bit pof, bit fd);
    exp_t e;
    e.st = 2'(st); e.pat = 3'(pat); e.pbit = 5'(pb); e.pix = 4'(pix);
    e.pmax = 4'(cur_pmax); e.chan = 2'(ch); e.bof = bof; e.pof = pof; e.fd = fd;
    return e;
  endfunction

  function automatic void push_frame(cfg_t c);
    int nch, npix, nbits;
    cur_pmax = pmax_of(c);
    nch   = ((c.chan > 2'd2) ? 2 : int'(c.chan)) + 1;
    npix  = c.b32 ? cur_pmax / 4 + 1 : cur_pmax + 1;
    nbits = c.rgbw ? 32 : 24;
    for (int ch = 0; ch < nch; ch++)
      for (int p = 0; p < npix; p++)
        for (int b = 0; b < nbits; b++)
          for (int s = 0; s < PS; s++) begin
            bit bof;
            bof = (s == PS - 1) && (b == nbits - 1);
            exp_q.push_back(mk(1, s, b, c.b32 ? 4 * p : p, ch, bof, bof && (p == npix - 1), 1'b0));
          end
  endfunction

  function automatic void push_reset();
    for (int r = 0; r < RC; r++) exp_q.push_back(mk(2, 0, 0, 0, 0, 1'b0, 1'b0, r == RC - 1));
  endfunction

  function automatic void push_idle();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rec(input string name);
    exp_t e;
    logic [24:0] act, expv;
    e = exp_q.pop_front();
    act  = {bus.state, bus.bit_pattern_index, bus.pixel_bit_index, bus.pixel_index,
            bus.pixel_index_max, bus.channel_index, bus.stream_output, bus.stream_reset,
            bus.stream_bit_of, bus.stream_pixel_of, bus.frame_done};
    expv = {e.st, e.pat, e.pbit, e.pix, e.pmax, e.chan, e.st == 2'd1, e.st == 2'd2,
            e.bof, e.pof, e.fd};
    if (bus.stream_output === 1'b1) tx_seen++;
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s t=%0t actual=%h required=%h (st,pat,bit,pix,pmax,ch,out,rst,bof,pof,fd)",
                 name, $time, act, expv);
    end
  endtask

  task automatic check_val(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic apply(input cfg_t c);
    bus.reg_ctrl_32bit = c.b32;
    bus.reg_ctrl_rgbw  = c.rgbw;
    bus.reg_ctrl_limit = c.limit;
    bus.reg_max        = c.rmax;
    bus.reg_chan_max   = c.chan;
  endtask

  task automatic start(input cfg_t c, input bit loop);
    apply(c);
    bus.reg_ctrl_loop = loop;
    bus.reg_ctrl_run  = 1'b1;
  endtask

  // Walks the expected queue one clock per record; hooks fire after the check at the given index.
  task automatic drain(input string name, input int abort_at, input int mut_at, input cfg_t mut,
                       input int drop_at, input int init_at);
    int i = 0;
    while (exp_q.size() > 0) begin
      step();
      check_rec(name);
      if (i == mut_at) apply(mut);
      if (i == drop_at) bus.reg_ctrl_run = 1'b0;
      if (i == abort_at) begin
        bus.reg_ctrl_run = 1'b0;
        exp_q.delete();
        push_reset();
        push_idle();
      end
      if (i == init_at) begin
        bus.reg_ctrl_init = 1'b1;
        bus.reg_ctrl_run  = 1'b0;
        exp_q.delete();
        cur_pmax = BE;
        push_idle();
      end
      i++;
    end
    bus.reg_ctrl_init = 1'b0;
  endtask

  task automatic one_shot(input string name, input cfg_t c, input int mut_at, input cfg_t mut);
    int d;
    start(c, 1'b0);
    push_frame(c);
    d = exp_q.size();
    push_reset();
    push_idle();
    drain(name, -1, mut_at, mut, d, -1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    cfg_t a, b, r;
    int   d;

    vecs[0] = '{'{1'b0, 1'b0, 1'b1, 13'd2,    2'd0},  576,  2};
    vecs[1] = '{'{1'b1, 1'b1, 1'b1, 13'd7,    2'd1}, 1024,  7};
    vecs[2] = '{'{1'b0, 1'b0, 1'b1, 13'd14,   2'd3}, 6912, 11};
    vecs[3] = '{'{1'b1, 1'b0, 1'b1, 13'h1003, 2'd1},  384,  3};
    vecs[4] = '{'{1'b1, 1'b1, 1'b0, 13'd0,    2'd0},  768, 11};
    vecs[5] = '{'{1'b0, 1'b1, 1'b1, 13'd0,    2'd2},  768,  0};

    bus.reg_ctrl_init = 1'b0; bus.reg_ctrl_run = 1'b0; bus.reg_ctrl_limit = 1'b0;
    bus.reg_ctrl_32bit = 1'b0; bus.reg_ctrl_rgbw = 1'b0; bus.reg_ctrl_loop = 1'b0;
    bus.reg_max = '0; bus.reg_chan_max = '0;

    #2;
    push_idle();
    check_rec("reset_state");
    #10 rst_n = 1'b1;

    foreach (vecs[k]) begin
      tx_seen = 0;
      one_shot($sformatf("vec%0d", k), vecs[k].cfg, -1, vecs[k].cfg);
      check_val($sformatf("vec%0d_tx_cycles", k), tx_seen, vecs[k].exp_tx);
      check_val($sformatf("vec%0d_pixmax", k), int'(bus.pixel_index_max), vecs[k].exp_pmax);
    end

    // Mid-frame register change must not affect the running frame.
    a = '{1'b0, 1'b0, 1'b1, 13'd2, 2'd0};
    b = '{1'b0, 1'b1, 1'b1, 13'd0, 2'd0};
    one_shot("midframe_old", a, 100, b);
    tx_seen = 0;
    one_shot("midframe_new", b, -1, b);
    check_val("midframe_new_tx", tx_seen, 256);

    // Looping, unlimited: pixel_index wraps BUFFER_END->0 and each frame ends with frame_done.
    a = '{1'b0, 1'b0, 1'b0, 13'd5, 2'd0};
    start(a, 1'b1);
    push_frame(a); push_reset(); push_frame(a);
    d = exp_q.size();
    push_reset(); push_idle();
    drain("loop", -1, -1, a, d, -1);
    bus.reg_ctrl_loop = 1'b0;

    // Abort mid-pixel, then init during the latch gap.
    a = '{1'b1, 1'b1, 1'b1, 13'd9, 2'd1};
    start(a, 1'b0);
    push_frame(a);
    drain("abort", 37, -1, a, -1, -1);
    start(a, 1'b0);
    push_frame(a);
    drain("init_mid_reset", 10, -1, a, -1, 110);

    // Asynchronous reset during the latch gap.
    start(a, 1'b0);
    repeat (20) step();
    bus.reg_ctrl_run = 1'b0;
    repeat (30) step();
    check_val("pre_rst_state", int'(bus.state), 2);
    #3 rst_n = 1'b0;
    #1;
    cur_pmax = BE;
    exp_q.delete();
    push_idle();
    check_rec("async_rst_mid_reset");
    #1 rst_n = 1'b1;
    push_idle();
    step();
    check_rec("idle_after_rst");

    for (int k = 0; k < 4; k++) begin
      r.b32 = 1'($urandom); r.rgbw = 1'($urandom); r.limit = 1'($urandom);
      r.rmax = 13'($urandom); r.chan = 2'($urandom_range(0, 3));
      one_shot($sformatf("rand%0d", k), r, -1, r);
    end
    r.b32 = 1'($urandom); r.rgbw = 1'($urandom); r.limit = 1'($urandom);
    r.rmax = 13'($urandom); r.chan = 2'($urandom_range(0, 3));
    start(r, 1'b0);
    push_frame(r);
    drain("rand_abort", int'($urandom_range(0, 150)), -1, r, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
